// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-stage controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} memState_t;

    typedef enum logic {RD, WR} access_t;

    // Mask of the byte-offset bits that must be zero for a word-aligned access.
    function automatic int unsigned alignMask(input int unsigned dataW);
        return (dataW / 8) - 1;
    endfunction

endpackage

// File: rtl/mem_perf_counters.sv
// Two saturating event counters for memory accesses and cache hits.
module mem_perf_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accessInc,
    input  logic             i_hitInc,
    output logic [CNT_W-1:0] o_accessCount,
    output logic [CNT_W-1:0] o_hitCount
);

    logic [CNT_W-1:0] r_accessCount;
    logic [CNT_W-1:0] r_hitCount;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_accessCount <= '0;
            r_hitCount    <= '0;
        end else begin
            if (i_accessInc && (r_accessCount != '1)) r_accessCount <= r_accessCount + 1'b1;
            if (i_hitInc && (r_hitCount != '1))       r_hitCount    <= r_hitCount + 1'b1;
        end
    end

    assign o_accessCount = r_accessCount;
    assign o_hitCount    = r_hitCount;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage handshake controller for a multi-cycle, stall-capable data memory.
// Optional access/hit counters are built when MEM_PERF_CNT_EN is defined.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] aluOutput,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              dump,
    output logic [DATA_W-1:0] readData,
    output logic              dataMemoryStallOut,
    output logic              memErr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memRd,
    output logic              memWr,
    output logic              memDump,
    input  logic              memStall,
    input  logic              memDone,
    input  logic              memCacheHit,
    input  logic              memErrIn,
    input  logic [DATA_W-1:0] memDataOut,
    output logic [CNT_W-1:0]  accessCount,
    output logic [CNT_W-1:0]  hitCount
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(alignMask(DATA_W));
    localparam int                WCNT_W     = $clog2(MAX_WAIT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(MAX_WAIT - 1);

    memState_t         r_state;
    memState_t         w_nextState;
    access_t           r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_readData;
    logic              r_memErr;
    logic [WCNT_W-1:0] r_waitCnt;

    logic w_validReq;
    logic w_aligned;
    logic w_badReq;
    logic w_accept;
    logic w_timeout;

    assign w_validReq = memRead ^ memWrite;
    assign w_aligned  = (aluOutput & ALIGN_MASK) == '0;
    assign w_badReq   = (memRead & memWrite) | (w_validReq & ~w_aligned);
    assign w_accept   = (r_state == REQ) && !memStall;
    assign w_timeout  = (r_state == WAIT) && !memDone && (r_waitCnt == WAIT_LAST);

    always_comb begin
        w_nextState        = r_state;
        dataMemoryStallOut = 1'b0;
        memRd              = 1'b0;
        memWr              = 1'b0;
        case (r_state)
            IDLE: begin
                dataMemoryStallOut = w_validReq && w_aligned;
                if (w_validReq && w_aligned) w_nextState = REQ;
            end
            REQ: begin
                dataMemoryStallOut = 1'b1;
                memRd              = (r_type == RD);
                memWr              = (r_type == WR);
                if (w_accept) w_nextState = WAIT;
            end
            WAIT: begin
                dataMemoryStallOut = 1'b1;
                if (memDone || w_timeout) w_nextState = DONE;
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // memDone takes priority over the timeout when both land on the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_type     <= RD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readData <= '0;
            r_memErr   <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            r_state  <= w_nextState;
            r_memErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_badReq) begin
                        r_memErr <= 1'b1;
                    end else if (w_validReq) begin
                        r_addr  <= aluOutput;
                        r_wdata <= writeData;
                        r_type  <= memWrite ? WR : RD;
                    end
                end
                REQ: if (w_accept) r_waitCnt <= '0;
                WAIT: begin
                    r_waitCnt <= r_waitCnt + 1'b1;
                    if (memDone) begin
                        if (r_type == RD) r_readData <= memDataOut;
                        r_memErr <= memErrIn;
                    end else if (w_timeout) begin
                        r_memErr   <= 1'b1;
                        r_readData <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign readData  = r_readData;
    assign memErr    = r_memErr;
    assign memAddr   = r_addr;
    assign memDataIn = r_wdata;
    assign memDump   = dump;

`ifdef MEM_PERF_CNT_EN
    logic w_memHit;
    assign w_memHit = (r_state == WAIT) && memDone && memCacheHit;

    mem_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_accessInc  (w_accept),
        .i_hitInc     (w_memHit),
        .o_accessCount(accessCount),
        .o_hitCount   (hitCount)
    );
`else
    logic w_unusedHit;
    assign w_unusedHit = memCacheHit;
    assign accessCount = '0;
    assign hitCount    = '0;
`endif

endmodule
